// File: rtl/avalonst_fifo_mm_capture_if.sv
// Bus bundle for the stream-to-MM capture FIFO: the Avalon-ST sink, the
// 4-word Avalon-MM slave and the capture_done level output.
//
// Handshake rules:
//   Stream: avalonst_sink_valid qualifies avalonst_sink_data on a rising
//   clock edge. There is no ready; the sink never stalls the source.
//   MM: read/write are single-cycle strobes qualified by address. readdata
//   is valid exactly one cycle after a read strobe. When read and write are
//   both high, the write wins and the read returns 0 without a pop.
interface avalonst_fifo_mm_capture_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] avalonst_sink_data;
  logic              avalonst_sink_valid;
  logic [1:0]        avalonmm_read_slave_address;
  logic              avalonmm_read_slave_read;
  logic              avalonmm_read_slave_write;
  logic [31:0]       avalonmm_read_slave_writedata;
  logic [31:0]       avalonmm_read_slave_readdata;
  logic              capture_done;

  modport master (
    output avalonst_sink_data,
    output avalonst_sink_valid,
    output avalonmm_read_slave_address,
    output avalonmm_read_slave_read,
    output avalonmm_read_slave_write,
    output avalonmm_read_slave_writedata,
    input  avalonmm_read_slave_readdata,
    input  capture_done
  );

  modport slave (
    input  avalonst_sink_data,
    input  avalonst_sink_valid,
    input  avalonmm_read_slave_address,
    input  avalonmm_read_slave_read,
    input  avalonmm_read_slave_write,
    input  avalonmm_read_slave_writedata,
    output avalonmm_read_slave_readdata,
    output capture_done
  );
endinterface

// File: rtl/avalonst_fifo_mm_capture.sv
// Stream-to-MM capture FIFO. Samples from an unstallable Avalon-ST source
// are buffered in block RAM and drained through a 4-word MM slave
// (DATA, STATUS, CONTROL, CAP_LEN). In triggered mode an armed one-shot
// capture takes CAP_LEN samples and then stops accepting.
module avalonst_fifo_mm_capture #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 13,
  parameter int CAPTURE_MODE = 0
) (
  input  logic                         clock,
  input  logic                         aclr,
  avalonst_fifo_mm_capture_if.slave    bus,
  output logic [1:0]                   o_dbg_state
);

  localparam int DEPTH_I = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_L   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [31:0]           DEPTH_W32 = 32'(DEPTH_I);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CAPLEN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Which source drives readdata in the cycle after a read.
  typedef enum logic [1:0] {
    RS_ZERO = 2'd0,
    RS_MEM  = 2'd1,
    RS_REG  = 2'd2
  } rsel_t;

  logic [DATA_W-1:0]     r_mem [DEPTH_I];
  logic [DATA_W-1:0]     r_mem_q;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   r_cap_len;
  logic [DEPTH_LOG2:0]   r_cap_cnt;
  logic                  r_overflow;
  logic                  r_underflow;
  state_t                r_state;
  rsel_t                 r_rsel;
  logic [31:0]           r_reg_q;

  state_t                w_state_nxt;
  logic [DEPTH_LOG2:0]   w_cap_cnt_nxt;
  logic [DEPTH_LOG2:0]   w_cnt_inc;
  logic [DEPTH_LOG2:0]   w_cap_len_wval;
  logic                  w_ctrl_wr;
  logic                  w_flush;
  logic                  w_arm;
  logic                  w_clr_err;
  logic                  w_caplen_wr;
  logic                  w_rd;
  logic                  w_armed;
  logic                  w_done;
  logic                  w_cap_open;
  logic                  w_accept;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_req;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [31:0]           w_status;
  logic [31:0]           w_cap_len_ext;
  logic [31:0]           w_mem_ext;

  // Decode MM strobes and stream acceptance; a write masks any read.
  always_comb begin
    w_ctrl_wr   = bus.avalonmm_read_slave_write && (bus.avalonmm_read_slave_address == ADDR_CTRL);
    w_flush     = w_ctrl_wr && bus.avalonmm_read_slave_writedata[0];
    w_arm       = w_ctrl_wr && bus.avalonmm_read_slave_writedata[1] && (CAPTURE_MODE == 1);
    w_clr_err   = w_ctrl_wr && bus.avalonmm_read_slave_writedata[2];
    w_caplen_wr = bus.avalonmm_read_slave_write && (bus.avalonmm_read_slave_address == ADDR_CAPLEN);
    w_rd        = bus.avalonmm_read_slave_read && !bus.avalonmm_read_slave_write;

    w_armed    = (r_state == S_ARMED);
    w_done     = (r_state == S_DONE);
    // Gate on the count as well so CAP_LEN=0 (or a shrink while armed)
    // never lets a sample in before the FSM reaches DONE.
    w_cap_open = w_armed && (r_cap_cnt < r_cap_len);
    w_accept   = bus.avalonst_sink_valid && ((CAPTURE_MODE == 0) || w_cap_open);

    w_empty = (r_level == '0);
    w_full  = (r_level == DEPTH_L);

    w_pop_req = w_rd && (bus.avalonmm_read_slave_address == ADDR_DATA);
    w_pop     = w_pop_req && !w_empty;
    w_udf_evt = w_pop_req && w_empty;
    // Push and pop both judge the pre-cycle level, so a pop frees room
    // for a same-cycle push even when full.
    w_push    = w_accept && (!w_full || w_pop) && !w_flush;
    w_ovf_evt = w_accept && w_full && !w_pop && !w_flush;

    if (bus.avalonmm_read_slave_writedata > DEPTH_W32) begin
      w_cap_len_wval = DEPTH_L;
    end else begin
      w_cap_len_wval = bus.avalonmm_read_slave_writedata[DEPTH_LOG2:0];
    end
  end

  // Assemble STATUS and the zero-extended CAP_LEN readback words.
  always_comb begin
    w_status                 = '0;
    w_status[DEPTH_LOG2:0]   = r_level;
    w_status[24]             = w_empty;
    w_status[25]             = w_full;
    w_status[26]             = r_overflow;
    w_status[27]             = r_underflow;
    w_status[28]             = w_armed;
    w_status[29]             = w_done;
    w_cap_len_ext                 = '0;
    w_cap_len_ext[DEPTH_LOG2:0]   = r_cap_len;
  end

  // Sample storage: write port plus a registered read of the head word.
  // No reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.avalonst_sink_data;
    end
    r_mem_q <= r_mem[r_rd_ptr];
  end

  // Pointers, level and sticky error flags.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_ONE;
          2'b01:   r_level <= r_level - LVL_ONE;
          default: r_level <= r_level;
        endcase
      end
      // A new error in the clearing cycle stays visible.
      if (w_ovf_evt)      r_overflow <= 1'b1;
      else if (w_clr_err) r_overflow <= 1'b0;
      if (w_udf_evt)      r_underflow <= 1'b1;
      else if (w_clr_err) r_underflow <= 1'b0;
    end
  end

  // Capture length register, saturated to the FIFO depth on write.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_cap_len <= DEPTH_L;
    end else if (w_caplen_wr) begin
      r_cap_len <= w_cap_len_wval;
    end
  end

  // Capture FSM state and sample counter.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state   <= S_IDLE;
      r_cap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cap_cnt <= w_cap_cnt_nxt;
    end
  end

  // Capture FSM next state: arm always restarts, ARMED ends once the
  // count of accepted samples reaches CAP_LEN.
  always_comb begin
    w_state_nxt   = r_state;
    w_cap_cnt_nxt = r_cap_cnt;
    w_cnt_inc     = r_cap_cnt + (w_accept ? LVL_ONE : '0);
    if (w_arm) begin
      w_state_nxt   = S_ARMED;
      w_cap_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_ARMED: begin
          w_cap_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= r_cap_len) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Register what the next readdata should show.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_rsel  <= RS_ZERO;
      r_reg_q <= '0;
    end else begin
      r_rsel  <= RS_ZERO;
      r_reg_q <= '0;
      if (w_rd) begin
        case (bus.avalonmm_read_slave_address)
          ADDR_DATA:   r_rsel <= w_pop ? RS_MEM : RS_ZERO;
          ADDR_STATUS: begin
            r_rsel  <= RS_REG;
            r_reg_q <= w_status;
          end
          ADDR_CAPLEN: begin
            r_rsel  <= RS_REG;
            r_reg_q <= w_cap_len_ext;
          end
          default:     r_rsel <= RS_ZERO;
        endcase
      end
    end
  end

  // Drive readdata and the capture status outputs.
  always_comb begin
    w_mem_ext               = '0;
    w_mem_ext[DATA_W-1:0]   = r_mem_q;
    case (r_rsel)
      RS_MEM:  bus.avalonmm_read_slave_readdata = w_mem_ext;
      RS_REG:  bus.avalonmm_read_slave_readdata = r_reg_q;
      default: bus.avalonmm_read_slave_readdata = '0;
    endcase
    bus.capture_done = w_done;
    o_dbg_state      = r_state;
  end

endmodule

// File: tb/tb_avalonst_fifo_mm_capture.sv
// Directed bench: one 8-deep continuous instance (bus0) and one 8-deep
// triggered instance (bus1).
module tb_avalonst_fifo_mm_capture;

  logic clock;
  logic aclr;
  logic [1:0] dbg0;
  logic [1:0] dbg1;
  int n_checks;
  int n_fail;

  avalonst_fifo_mm_capture_if #(.DATA_W(32)) bus0 ();
  avalonst_fifo_mm_capture_if #(.DATA_W(32)) bus1 ();

  avalonst_fifo_mm_capture #(.DATA_W(32), .DEPTH_LOG2(3), .CAPTURE_MODE(0)) u_dut0 (
    .clock       (clock),
    .aclr        (aclr),
    .bus         (bus0.slave),
    .o_dbg_state (dbg0)
  );

  avalonst_fifo_mm_capture #(.DATA_W(32), .DEPTH_LOG2(3), .CAPTURE_MODE(1)) u_dut1 (
    .clock       (clock),
    .aclr        (aclr),
    .bus         (bus1.slave),
    .o_dbg_state (dbg1)
  );

  // Clock and reset.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks.
  task automatic drive(input int sel, input logic v, input logic [31:0] d,
                       input logic rd, input logic wr, input logic [1:0] a,
                       input logic [31:0] wd);
    if (sel == 0) begin
      bus0.avalonst_sink_valid = v;  bus0.avalonst_sink_data = d;
      bus0.avalonmm_read_slave_read = rd;  bus0.avalonmm_read_slave_write = wr;
      bus0.avalonmm_read_slave_address = a;  bus0.avalonmm_read_slave_writedata = wd;
    end else begin
      bus1.avalonst_sink_valid = v;  bus1.avalonst_sink_data = d;
      bus1.avalonmm_read_slave_read = rd;  bus1.avalonmm_read_slave_write = wr;
      bus1.avalonmm_read_slave_address = a;  bus1.avalonmm_read_slave_writedata = wd;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic step(input int sel, input logic v, input logic [31:0] d,
                      input logic rd, input logic wr, input logic [1:0] a,
                      input logic [31:0] wd);
    drive(sel, v, d, rd, wr, a, wd);
    tick();
    idle_all();
  endtask

  function automatic logic [31:0] rdata(input int sel);
    return (sel == 0) ? bus0.avalonmm_read_slave_readdata : bus1.avalonmm_read_slave_readdata;
  endfunction

  function automatic logic cdone(input int sel);
    return (sel == 0) ? bus0.capture_done : bus1.capture_done;
  endfunction

  task automatic push(input int sel, input logic [31:0] d);
    step(sel, 1'b1, d, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic mm_write(input int sel, input logic [1:0] a, input logic [31:0] wd);
    step(sel, 1'b0, 32'h0, 1'b0, 1'b1, a, wd);
  endtask

  task automatic mm_read(input int sel, input logic [1:0] a, output logic [31:0] q);
    step(sel, 1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0);
    q = rdata(sel);
  endtask

  // Reset values on both instances.
  task automatic test_reset();
    logic [31:0] q;
    n_checks++;
    if (rdata(0) !== 32'h0) begin
      $display("FAIL reset_readdata got=%h exp=%h", rdata(0), 32'h0); n_fail++;
    end
    n_checks++;
    if (cdone(1) !== 1'b0) begin
      $display("FAIL reset_capture_done got=%b exp=0", cdone(1)); n_fail++;
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0100_0000) begin
      $display("FAIL reset_status got=%h exp=%h", q, 32'h0100_0000); n_fail++;
    end
    mm_read(1, 2'd3, q);
    n_checks++;
    if (q !== 32'h8) begin
      $display("FAIL reset_caplen got=%h exp=%h", q, 32'h8); n_fail++;
    end
    mm_read(0, 2'd2, q);
    n_checks++;
    if (q !== 32'h0) begin
      $display("FAIL control_read got=%h exp=%h", q, 32'h0); n_fail++;
    end
  endtask

  // Fill with 0x11..0x18 then drain in order.
  task automatic test_fill_drain();
    logic [31:0] q;
    for (int i = 0; i < 8; i++) push(0, 32'h11 + i);
    for (int i = 0; i < 8; i++) begin
      mm_read(0, 2'd0, q);
      n_checks++;
      if (q !== 32'h11 + i) begin
        $display("FAIL fill_drain_data[%0d] got=%h exp=%h", i, q, 32'h11 + i); n_fail++;
      end
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0100_0000) begin
      $display("FAIL fill_drain_status got=%h exp=%h", q, 32'h0100_0000); n_fail++;
    end
  endtask

  // Push 10 into 8 deep: two dropped, overflow sticky until cleared.
  task automatic test_overflow();
    logic [31:0] q;
    for (int i = 1; i <= 10; i++) push(0, i);
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0600_0008) begin
      $display("FAIL overflow_status got=%h exp=%h", q, 32'h0600_0008); n_fail++;
    end
    for (int i = 1; i <= 8; i++) begin
      mm_read(0, 2'd0, q);
      n_checks++;
      if (q !== i) begin
        $display("FAIL overflow_data[%0d] got=%h exp=%h", i, q, i); n_fail++;
      end
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0500_0000) begin
      $display("FAIL overflow_sticky got=%h exp=%h", q, 32'h0500_0000); n_fail++;
    end
    mm_write(0, 2'd2, 32'h4);
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0100_0000) begin
      $display("FAIL overflow_clear got=%h exp=%h", q, 32'h0100_0000); n_fail++;
    end
  endtask

  // Pop on empty, then simultaneous push+pop on empty.
  task automatic test_underflow();
    logic [31:0] q;
    mm_read(0, 2'd0, q);
    n_checks++;
    if (q !== 32'h0) begin
      $display("FAIL underflow_data got=%h exp=%h", q, 32'h0); n_fail++;
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0900_0000) begin
      $display("FAIL underflow_status got=%h exp=%h", q, 32'h0900_0000); n_fail++;
    end
    step(0, 1'b1, 32'hAB, 1'b1, 1'b0, 2'd0, 32'h0);
    q = rdata(0);
    n_checks++;
    if (q !== 32'h0) begin
      $display("FAIL empty_pushpop_data got=%h exp=%h", q, 32'h0); n_fail++;
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0800_0001) begin
      $display("FAIL empty_pushpop_status got=%h exp=%h", q, 32'h0800_0001); n_fail++;
    end
    mm_read(0, 2'd0, q);
    n_checks++;
    if (q !== 32'hAB) begin
      $display("FAIL empty_pushpop_pop got=%h exp=%h", q, 32'hAB); n_fail++;
    end
    mm_write(0, 2'd2, 32'h4);
  endtask

  // Full FIFO: push+pop together is accepted without overflow.
  task automatic test_full_pushpop();
    logic [31:0] q;
    logic [31:0] exp_q[$];
    for (int i = 0; i < 8; i++) push(0, 32'h21 + i);
    step(0, 1'b1, 32'h99, 1'b1, 1'b0, 2'd0, 32'h0);
    q = rdata(0);
    n_checks++;
    if (q !== 32'h21) begin
      $display("FAIL full_pushpop_data got=%h exp=%h", q, 32'h21); n_fail++;
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0200_0008) begin
      $display("FAIL full_pushpop_status got=%h exp=%h", q, 32'h0200_0008); n_fail++;
    end
    for (int i = 1; i < 8; i++) exp_q.push_back(32'h21 + i);
    exp_q.push_back(32'h99);
    for (int i = 0; i < 8; i++) begin
      mm_read(0, 2'd0, q);
      n_checks++;
      if (q !== exp_q[i]) begin
        $display("FAIL full_pushpop_drain[%0d] got=%h exp=%h", i, q, exp_q[i]); n_fail++;
      end
    end
  endtask

  // Read+write collision, CAP_LEN saturation, flush with same-cycle push.
  task automatic test_control();
    logic [31:0] q;
    push(0, 32'h31);
    step(0, 1'b0, 32'h0, 1'b1, 1'b1, 2'd3, 32'd100);
    q = rdata(0);
    n_checks++;
    if (q !== 32'h0) begin
      $display("FAIL rw_collision_data got=%h exp=%h", q, 32'h0); n_fail++;
    end
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0000_0001) begin
      $display("FAIL rw_collision_status got=%h exp=%h", q, 32'h1); n_fail++;
    end
    mm_read(0, 2'd3, q);
    n_checks++;
    if (q !== 32'h8) begin
      $display("FAIL caplen_saturate got=%h exp=%h", q, 32'h8); n_fail++;
    end
    mm_write(0, 2'd3, 32'd5);
    mm_read(0, 2'd3, q);
    n_checks++;
    if (q !== 32'h5) begin
      $display("FAIL caplen_write got=%h exp=%h", q, 32'h5); n_fail++;
    end
    mm_read(0, 2'd0, q);
    n_checks++;
    if (q !== 32'h31) begin
      $display("FAIL rw_collision_pop got=%h exp=%h", q, 32'h31); n_fail++;
    end
    push(0, 32'h01);
    step(0, 1'b1, 32'h02, 1'b0, 1'b1, 2'd2, 32'h3);
    mm_read(0, 2'd1, q);
    n_checks++;
    if (q !== 32'h0100_0000) begin
      $display("FAIL flush_status got=%h exp=%h", q, 32'h0100_0000); n_fail++;
    end
    n_checks++;
    if (cdone(0) !== 1'b0) begin
      $display("FAIL mode0_capture_done got=%b exp=0", cdone(0)); n_fail++;
    end
  endtask

  // Triggered capture of 5 samples, then CAP_LEN=0 capture.
  task automatic test_capture();
    logic [31:0] q;
    mm_write(1, 2'd3, 32'd5);
    mm_write(1, 2'd2, 32'h2);
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h1100_0000) begin
      $display("FAIL capture_armed_status got=%h exp=%h", q, 32'h1100_0000); n_fail++;
    end
    for (int i = 0; i < 20; i++) begin
      push(1, 32'h40 + i);
      n_checks++;
      if (cdone(1) !== (i >= 4)) begin
        $display("FAIL capture_done_timing[%0d] got=%b exp=%b", i, cdone(1), (i >= 4)); n_fail++;
      end
    end
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h2000_0005) begin
      $display("FAIL capture_done_status got=%h exp=%h", q, 32'h2000_0005); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      mm_read(1, 2'd0, q);
      n_checks++;
      if (q !== 32'h40 + i) begin
        $display("FAIL capture_data[%0d] got=%h exp=%h", i, q, 32'h40 + i); n_fail++;
      end
    end
    mm_write(1, 2'd3, 32'd0);
    mm_write(1, 2'd2, 32'h2);
    n_checks++;
    if (cdone(1) !== 1'b0) begin
      $display("FAIL rearm_clears_done got=%b exp=0", cdone(1)); n_fail++;
    end
    for (int i = 0; i < 3; i++) push(1, 32'h55 + i);
    n_checks++;
    if (cdone(1) !== 1'b1) begin
      $display("FAIL caplen0_done got=%b exp=1", cdone(1)); n_fail++;
    end
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h2100_0000) begin
      $display("FAIL caplen0_status got=%h exp=%h", q, 32'h2100_0000); n_fail++;
    end
  endtask

  // Async reset mid-capture, then flush+arm restart.
  task automatic test_aclr_mid_capture();
    logic [31:0] q;
    mm_write(1, 2'd3, 32'd8);
    mm_write(1, 2'd2, 32'h2);
    for (int i = 0; i < 3; i++) push(1, 32'h61 + i);
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h1000_0003) begin
      $display("FAIL precapture_status got=%h exp=%h", q, 32'h1000_0003); n_fail++;
    end
    mm_read(1, 2'd1, q);
    aclr = 1'b1;
    #2;
    aclr = 1'b0;
    n_checks++;
    if (rdata(1) !== 32'h0) begin
      $display("FAIL aclr_readdata got=%h exp=%h", rdata(1), 32'h0); n_fail++;
    end
    n_checks++;
    if (cdone(1) !== 1'b0) begin
      $display("FAIL aclr_capture_done got=%b exp=0", cdone(1)); n_fail++;
    end
    tick();
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h0100_0000) begin
      $display("FAIL aclr_status got=%h exp=%h", q, 32'h0100_0000); n_fail++;
    end
    mm_write(1, 2'd2, 32'h3);
    mm_read(1, 2'd1, q);
    n_checks++;
    if (q !== 32'h1100_0000) begin
      $display("FAIL rearm_status got=%h exp=%h", q, 32'h1100_0000); n_fail++;
    end
    push(1, 32'h77);
    mm_read(1, 2'd0, q);
    n_checks++;
    if (q !== 32'h77) begin
      $display("FAIL rearm_data got=%h exp=%h", q, 32'h77); n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    aclr     = 1'b1;
    idle_all();
    repeat (3) tick();
    aclr = 1'b0;
    tick();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_control();
    test_capture();
    test_aclr_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
